// File: rtl/conn_sched_pkg.sv
// Shared constants and types for the connection request scheduler:
// channel encodings, FSM state type and default geometry.
package conn_sched_pkg;

    localparam int DEF_NODE   = 16;
    localparam int DEF_ADDR_W = 4;

    localparam logic [1:0] CH_X = 2'd0;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_Z = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/conn_rr_arb.sv
// Round-robin search: returns the first set bit of pending at or after
// ptr, wrapping at N. Purely combinational.
module conn_rr_arb #(
    parameter int N = 48,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] grant
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        valid = 1'b0;
        grant = '0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = IW'(j);
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/conn_req_sched.sv
// Connection request scheduler: captures rising edges on 3*NODE request
// lines, arbitrates round-robin over channel*NODE+node and issues each
// event over a 4-phase req/ack handshake carrying {channel, node}.
// Optional feature: define CONN_REQ_SCHED_DROP_CNT_EN to add a
// saturating drop_cnt output counting events merged into a flag that
// was already pending.
//
// Handshake: aer_req rises only from IDLE with aer_addr already stable;
// aer_addr holds until aer_ack is seen high, after which aer_req drops
// and the FSM waits for aer_ack low before it may grant again.
module conn_req_sched
    import conn_sched_pkg::*;
#(
    parameter int NODE   = DEF_NODE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NODE-1:0]   request_x,
    input  logic [NODE-1:0]   request_y,
    input  logic [NODE-1:0]   request_z,
    output logic              aer_req,
    input  logic              aer_ack,
    output logic [ADDR_W+1:0] aer_addr,
    output logic              busy,
`ifdef CONN_REQ_SCHED_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output state_t            state_dbg
);

    localparam int NS = 3 * NODE;
    localparam int IW = $clog2(NS);

    logic [NS-1:0]     req_in;
    logic [NS-1:0]     samp_q;
    logic [NS-1:0]     prev_q;
    logic [NS-1:0]     rise;
    logic [NS-1:0]     pending_q;
    logic [NS-1:0]     pending_d;
    logic [NS-1:0]     clr;
    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     grant;
    logic              gnt_valid;
    logic              take;
    logic [1:0]        ch_d;
    logic [ADDR_W-1:0] node_d;

    // Flat vector: bit index = channel*NODE + node.
    assign req_in = {request_z, request_y, request_x};

    // Two-stage sampling; an edge is a 0->1 between consecutive samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q <= '0;
            prev_q <= '0;
        end else begin
            samp_q <= req_in;
            prev_q <= samp_q;
        end
    end

    assign rise = samp_q & ~prev_q;

    conn_rr_arb #(
        .N(NS)
    ) u_arb (
        .pending(pending_q),
        .ptr    (ptr_q),
        .valid  (gnt_valid),
        .grant  (grant)
    );

    // Next-state logic; a grant is taken only from IDLE with en high.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && gnt_valid) begin
                    take    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (aer_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!aer_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending update: a new edge wins over a same-cycle grant clear.
    always_comb begin
        clr = '0;
        if (take) begin
            clr[grant] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    // Split the flat grant index into channel and node.
    always_comb begin
        ch_d   = CH_X;
        node_d = '0;
        if (int'(grant) < NODE) begin
            ch_d   = CH_X;
            node_d = ADDR_W'(grant);
        end else if (int'(grant) < 2 * NODE) begin
            ch_d   = CH_Y;
            node_d = ADDR_W'(int'(grant) - NODE);
        end else begin
            ch_d   = CH_Z;
            node_d = ADDR_W'(int'(grant) - 2 * NODE);
        end
    end

    // State, registered handshake outputs, pointer and pending flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            aer_req   <= 1'b0;
            aer_addr  <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            aer_req   <= (state_d == SEND);
            pending_q <= pending_d;
            if (take) begin
                aer_addr <= {ch_d, node_d};
                ptr_q    <= (int'(grant) == NS - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    assign busy      = (|pending_q) || (state_q != IDLE);
    assign state_dbg = state_q;

`ifdef CONN_REQ_SCHED_DROP_CNT_EN
    localparam int MW = $clog2(NS + 1);

    logic [NS-1:0] merged;
    logic [MW-1:0] merge_n;
    logic [16:0]   drop_sum;

    // Edges landing on a flag that stays set this cycle are lost events.
    always_comb begin
        merged  = rise & pending_q & ~clr;
        merge_n = '0;
        for (int i = 0; i < NS; i++) begin
            merge_n = merge_n + MW'(merged[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 17'(merge_n);
    end

    // Saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_sum[16]) begin
            drop_cnt <= 16'hFFFF;
        end else begin
            drop_cnt <= drop_sum[15:0];
        end
    end
`endif

endmodule

// File: doc/conn_req_sched.md
CONN_REQ_SCHED -- requirements
Module: conn_req_sched

Interface
REQ-001 Parameter NODE, default 16, number of connection nodes per request channel.
REQ-002 Parameter ADDR_W, default 4, node-address width; SHALL satisfy 2**ADDR_W >= NODE.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  scheduling enable; low blocks new grants.
REQ-006 request_x, request_y, request_z  input  NODE each  level request lines from the connection fabric.
REQ-007 aer_req  output  1  4-phase output request.
REQ-008 aer_ack  input  1  4-phase acknowledge from the downstream sender.
REQ-009 aer_addr  output  ADDR_W+2  {channel[1:0], node[ADDR_W-1:0]}; channel encoding x=0, y=1, z=2.
REQ-010 busy  output  1  high when any pending flag is set or the FSM is not IDLE.

Function
REQ-011 Each of the 3*NODE request bits SHALL be registered; a 0->1 transition relative to the previous sample SHALL set that bit's pending flag on the next clk edge.
REQ-012 Flat source index = channel*NODE + node; arbitration SHALL be round-robin over this index, starting search at ptr; ptr resets to 0.
REQ-013 FSM states IDLE, SEND, RELEASE; reset state IDLE.
REQ-014 IDLE: if en=1 and any pending, grant the first pending index at or after ptr (wrapping); latch aer_addr, clear that pending flag, set ptr=(grant+1) mod 3*NODE, go to SEND.
REQ-015 SEND: aer_req=1, aer_addr held stable; on aer_ack=1 go to RELEASE.
REQ-016 RELEASE: aer_req=0; on aer_ack=0 go to IDLE.
REQ-017 aer_req SHALL be a registered output, high exactly in SEND; latency from the edge registering an input rise to aer_req=1 is 2 clocks when IDLE, en=1 and no other pending.
REQ-018 Rising edge on a bit whose pending flag is already set SHALL be merged (no second event).
REQ-019 Rising edge on a bit in the same cycle its flag is cleared by grant SHALL leave the flag set.
REQ-020 en=0 during SEND/RELEASE SHALL NOT abort the handshake; edge capture continues while en=0.
REQ-021 aer_ack=1 while in IDLE SHALL be ignored.

Reset
REQ-022 On rst: aer_req=0, aer_addr=0, busy=0, all pending flags 0, input sample registers 0, ptr=0, state IDLE, counter (if present) 0.
REQ-023 rst asserted mid-handshake SHALL immediately drop aer_req and discard all pending events.
REQ-024 Lines high when rst deasserts SHALL be captured as rising edges on the first clock after release.

Configuration
REQ-025 Macro CONN_REQ_SCHED_DROP_CNT_EN: when defined, add output drop_cnt [15:0] counting merged events (REQ-018), saturating at 16'hFFFF; when undefined, no port and no counter logic.

Structure
REQ-026 Package conn_sched_pkg SHALL hold channel encodings (CH_X, CH_Y, CH_Z), FSM state typedef and the default NODE/ADDR_W constants.
REQ-027 Round-robin search SHALL be the sub-module conn_rr_arb (parameter N, inputs pending and ptr, outputs valid and grant index).

Verification
REQ-028 Reset, then request_x[3] 0->1, ack responds in 1 clock -> aer_addr={0,3}, aer_req high 2 clocks after sampled edge; busy low after handshake.
REQ-029 request_x[0], request_y[0], request_z[15] rise together, ptr=0 -> grant order addr {0,0}, {1,0}, {2,15}; ptr ends at 0.
REQ-030 request_z[5] toggles 3 times while first event pending -> one event issued; drop_cnt=2 with macro, port absent without it.
REQ-031 en=0 with 4 pending -> no aer_req; in-flight handshake completes; en=1 -> 4 events in round-robin order.
REQ-032 rst pulse while in SEND with 3 pending -> aer_req=0 asynchronously; after release no events until a new rising edge.
REQ-033 Hold aer_ack low 50 clocks in SEND -> aer_req and aer_addr stable throughout.
